// File: rtl/wb_snoop_poll_ctrl.sv
// Snoop-side sequencer: broadcasts a snoop to every peer core, collects poll responses
// until all peers resolve or a timeout expires, and reports the lowest-index hit.
module wb_snoop_poll_ctrl #(
    parameter int unsigned num_cores = 4,
    parameter int unsigned aw        = 32,
    parameter int unsigned dw        = 32,
    parameter int unsigned timeout   = 15,
    localparam int unsigned cw       = (num_cores > 1) ? $clog2(num_cores) : 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    req_i,
    input  logic [cw-1:0]           req_core_i,
    input  logic [aw-1:0]           req_adr_i,
    input  logic                    req_we_i,
    output logic [num_cores*aw-1:0] snoop_adr_o,
    output logic [1:0]              snoop_type_o,
    input  logic [num_cores*2-1:0]  snoop_response_i,
    input  logic [num_cores*dw-1:0] snooped_dat_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    hit_o,
    output logic [cw-1:0]           hit_core_o,
    output logic [dw-1:0]           hit_dat_o,
    output logic                    timeout_o
);

    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StPoll = 4'b0010,
        StWait = 4'b0100,
        StResp = 4'b1000
    } state_e;

    localparam logic [7:0] CntLast = 8'(timeout - 1);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [cw-1:0]   core_q, core_d;
    logic [aw-1:0]   adr_q, adr_d;
    logic            we_q, we_d;
    logic            hit_q, hit_d;
    logic [cw-1:0]   hit_core_q, hit_core_d;
    logic [dw-1:0]   hit_dat_q, hit_dat_d;
    logic            to_q, to_d;

    logic            all_resolved;
    logic            any_hit;
    logic [cw-1:0]   first_hit_core;
    logic [dw-1:0]   first_hit_dat;
    logic            snooping;

    // Response scan; the requester's own slot is masked out. Ascending order with a
    // found flag gives lowest-index priority among multiple positive responders.
    always_comb begin
        all_resolved   = 1'b1;
        any_hit        = 1'b0;
        first_hit_core = '0;
        first_hit_dat  = '0;
        for (int unsigned k = 0; k < num_cores; k++) begin
            if (cw'(k) != core_q) begin
                if (snoop_response_i[2*k +: 2] == 2'b10) begin
                    all_resolved = 1'b0;
                end
                if (snoop_response_i[2*k +: 2] == 2'b11 && !any_hit) begin
                    any_hit        = 1'b1;
                    first_hit_core = cw'(k);
                    first_hit_dat  = snooped_dat_i[k*dw +: dw];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        core_d     = core_q;
        adr_d      = adr_q;
        we_d       = we_q;
        hit_d      = hit_q;
        hit_core_d = hit_core_q;
        hit_dat_d  = hit_dat_q;
        to_d       = to_q;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    core_d     = req_core_i;
                    adr_d      = req_adr_i;
                    we_d       = req_we_i;
                    cnt_d      = '0;
                    hit_d      = 1'b0;
                    hit_core_d = '0;
                    hit_dat_d  = '0;
                    to_d       = 1'b0;
                    state_d    = StPoll;
                end
            end
            StPoll: begin
                state_d = StWait;
            end
            StWait: begin
                if (all_resolved || cnt_q == CntLast) begin
                    state_d = StResp;
                    to_d    = !all_resolved;
                    // Unresolved peers count as negative, so only 11 responders can hit.
                    if (!we_q && any_hit) begin
                        hit_d      = 1'b1;
                        hit_core_d = first_hit_core;
                        hit_dat_d  = first_hit_dat;
                    end else begin
                        hit_d      = 1'b0;
                        hit_core_d = '0;
                        hit_dat_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            core_q     <= '0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            hit_core_q <= '0;
            hit_dat_q  <= '0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            core_q     <= core_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            hit_q      <= hit_d;
            hit_core_q <= hit_core_d;
            hit_dat_q  <= hit_dat_d;
            to_q       <= to_d;
        end
    end

    assign snooping = (state_q == StPoll) || (state_q == StWait);

    always_comb begin
        snoop_type_o = 2'b00;
        snoop_adr_o  = '0;
        if (snooping) begin
            snoop_type_o = we_q ? 2'b10 : 2'b01;
            for (int unsigned k = 0; k < num_cores; k++) begin
                if (cw'(k) != core_q) begin
                    snoop_adr_o[k*aw +: aw] = adr_q;
                end
            end
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StResp);
    assign timeout_o  = (state_q == StResp) && to_q;
    assign hit_o      = hit_q;
    assign hit_core_o = hit_core_q;
    assign hit_dat_o  = hit_dat_q;

endmodule

// File: tb/tb_wb_snoop_poll_ctrl.sv
// Directed bench for wb_snoop_poll_ctrl with four cores and a timeout of 15 cycles.
module tb_wb_snoop_poll_ctrl;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic              clk;
    logic              rst_n;
    logic              req;
    logic [CW-1:0]     req_core;
    logic [AW-1:0]     req_adr;
    logic              req_we;
    logic [NC*AW-1:0]  snoop_adr;
    logic [1:0]        snoop_type;
    logic [NC*2-1:0]   snoop_resp;
    logic [NC*DW-1:0]  snoop_dat;
    logic              busy;
    logic              done;
    logic              hit;
    logic [CW-1:0]     hit_core;
    logic [DW-1:0]     hit_dat;
    logic              tmo;

    int n_checks = 0;
    int n_fail   = 0;

    wb_snoop_poll_ctrl #(
        .num_cores (NC),
        .aw        (AW),
        .dw        (DW),
        .timeout   (15)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst_n),
        .req_i            (req),
        .req_core_i       (req_core),
        .req_adr_i        (req_adr),
        .req_we_i         (req_we),
        .snoop_adr_o      (snoop_adr),
        .snoop_type_o     (snoop_type),
        .snoop_response_i (snoop_resp),
        .snooped_dat_i    (snoop_dat),
        .busy_o           (busy),
        .done_o           (done),
        .hit_o            (hit),
        .hit_core_o       (hit_core),
        .hit_dat_o        (hit_dat),
        .timeout_o        (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a request into the edge that follows; returns just after E0 (POLL).
    task automatic start(input logic [CW-1:0] core, input logic [AW-1:0] adr, input logic we);
        req      = 1'b1;
        req_core = core;
        req_adr  = adr;
        req_we   = we;
        step();
        req      = 1'b0;
    endtask

    task automatic set_resp(input logic [1:0] r0, input logic [1:0] r1,
                            input logic [1:0] r2, input logic [1:0] r3);
        snoop_resp = {r3, r2, r1, r0};
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_type"}, 64'(snoop_type), 64'd0);
        check_eq({tag, "_adr_lo"}, snoop_adr[63:0], 64'd0);
        check_eq({tag, "_adr_hi"}, snoop_adr[127:64], 64'd0);
        check_eq({tag, "_hit"}, 64'(hit), 64'd0);
        check_eq({tag, "_hcore"}, 64'(hit_core), 64'd0);
        check_eq({tag, "_hdat"}, 64'(hit_dat), 64'd0);
        check_eq({tag, "_tmo"}, 64'(tmo), 64'd0);
    endtask

    int n;
    int done_seen;

    initial begin
        rst_n      = 1'b0;
        req        = 1'b0;
        req_core   = '0;
        req_adr    = '0;
        req_we     = 1'b0;
        snoop_resp = '0;
        snoop_dat  = '0;
        step();
        step();
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Read miss, requester 0
        set_resp(2'b00, 2'b00, 2'b00, 2'b00);
        start(2'd0, 32'h100, 1'b0);
        check_eq("miss_poll_busy", 64'(busy), 64'd1);
        check_eq("miss_poll_type", 64'(snoop_type), 64'd1);
        check_eq("miss_adr0", 64'(snoop_adr[31:0]), 64'd0);
        check_eq("miss_adr1", 64'(snoop_adr[63:32]), 64'h100);
        check_eq("miss_adr2", 64'(snoop_adr[95:64]), 64'h100);
        check_eq("miss_adr3", 64'(snoop_adr[127:96]), 64'h100);
        check_eq("miss_poll_done", 64'(done), 64'd0);
        step();
        check_eq("miss_wait_type", 64'(snoop_type), 64'd1);
        check_eq("miss_wait_done", 64'(done), 64'd0);
        step();
        check_eq("miss_resp_done", 64'(done), 64'd1);
        check_eq("miss_resp_hit", 64'(hit), 64'd0);
        check_eq("miss_resp_tmo", 64'(tmo), 64'd0);
        check_eq("miss_resp_type", 64'(snoop_type), 64'd0);
        step();
        check_eq("miss_idle_done", 64'(done), 64'd0);
        check_eq("miss_idle_busy", 64'(busy), 64'd0);

        // Read hit, two positive peers: lowest index wins
        set_resp(2'b00, 2'b00, 2'b11, 2'b11);
        snoop_dat = {32'd99, 32'd64, 32'd7, 32'd5};
        start(2'd1, 32'h200, 1'b0);
        check_eq("hit_adr1", 64'(snoop_adr[63:32]), 64'd0);
        check_eq("hit_adr0", 64'(snoop_adr[31:0]), 64'h200);
        step();
        step();
        check_eq("hit_done", 64'(done), 64'd1);
        check_eq("hit_hit", 64'(hit), 64'd1);
        check_eq("hit_core", 64'(hit_core), 64'd2);
        check_eq("hit_dat", 64'(hit_dat), 64'd64);
        snoop_dat = '0;
        set_resp(2'b00, 2'b00, 2'b00, 2'b00);
        step();
        step();
        step();
        check_eq("hold_done", 64'(done), 64'd0);
        check_eq("hold_hit", 64'(hit), 64'd1);
        check_eq("hold_core", 64'(hit_core), 64'd2);
        check_eq("hold_dat", 64'(hit_dat), 64'd64);

        // Masked requester stuck at 10, then at 11
        set_resp(2'b00, 2'b00, 2'b10, 2'b00);
        start(2'd2, 32'h300, 1'b0);
        step();
        step();
        check_eq("mask10_done", 64'(done), 64'd1);
        check_eq("mask10_tmo", 64'(tmo), 64'd0);
        check_eq("mask10_hit", 64'(hit), 64'd0);
        step();
        set_resp(2'b00, 2'b00, 2'b11, 2'b00);
        snoop_dat = {32'd0, 32'h77, 32'd0, 32'd0};
        start(2'd2, 32'h300, 1'b0);
        step();
        step();
        check_eq("mask11_done", 64'(done), 64'd1);
        check_eq("mask11_hit", 64'(hit), 64'd0);
        check_eq("mask11_dat", 64'(hit_dat), 64'd0);
        step();

        // Write poll: a positive peer never reports a hit
        set_resp(2'b00, 2'b11, 2'b00, 2'b00);
        snoop_dat = {32'd1, 32'd2, 32'hDEAD, 32'd4};
        start(2'd2, 32'h400, 1'b1);
        check_eq("wr_type", 64'(snoop_type), 64'd2);
        check_eq("wr_adr2", 64'(snoop_adr[95:64]), 64'd0);
        check_eq("wr_adr1", 64'(snoop_adr[63:32]), 64'h400);
        step();
        step();
        check_eq("wr_done", 64'(done), 64'd1);
        check_eq("wr_hit", 64'(hit), 64'd0);
        check_eq("wr_dat", 64'(hit_dat), 64'd0);
        check_eq("wr_core", 64'(hit_core), 64'd0);
        step();
        check_eq("wr_done_pulse", 64'(done), 64'd0);

        // Timeout: core3 never resolves; core1 hit still reported
        set_resp(2'b00, 2'b11, 2'b00, 2'b10);
        snoop_dat = {32'd0, 32'd0, 32'h55, 32'd0};
        start(2'd0, 32'h500, 1'b0);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        check_eq("tmo_latency", 64'(n), 64'd16);
        check_eq("tmo_done", 64'(done), 64'd1);
        check_eq("tmo_flag", 64'(tmo), 64'd1);
        check_eq("tmo_hit", 64'(hit), 64'd1);
        check_eq("tmo_core", 64'(hit_core), 64'd1);
        check_eq("tmo_dat", 64'(hit_dat), 64'h55);
        step();
        check_eq("tmo_flag_drop", 64'(tmo), 64'd0);
        check_eq("tmo_idle", 64'(busy), 64'd0);

        // Ignored request during WAIT
        set_resp(2'b00, 2'b10, 2'b10, 2'b10);
        snoop_dat = '0;
        start(2'd0, 32'h600, 1'b0);
        step();
        req      = 1'b1;
        req_core = 2'd1;
        req_adr  = 32'hABC;
        req_we   = 1'b1;
        step();
        req = 1'b0;
        check_eq("ign_type", 64'(snoop_type), 64'd1);
        check_eq("ign_adr1", 64'(snoop_adr[63:32]), 64'h600);
        check_eq("ign_adr0", 64'(snoop_adr[31:0]), 64'd0);
        set_resp(2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_eq("ign_done", 64'(done), 64'd1);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        check_eq("ign_no_second", 64'(done_seen), 64'd0);

        // Asynchronous reset mid-WAIT
        set_resp(2'b00, 2'b10, 2'b00, 2'b11);
        snoop_dat = {32'h33, 32'd0, 32'd0, 32'd0};
        start(2'd0, 32'h700, 1'b0);
        step();
        step();
        check_eq("rst_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        step();
        rst_n = 1'b1;
        set_resp(2'b00, 2'b00, 2'b00, 2'b00);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) done_seen++;
        end
        check_eq("rst_no_done", 64'(done_seen), 64'd0);

        // First edge after reset release accepts a request
        start(2'd3, 32'h800, 1'b0);
        check_eq("post_rst_busy", 64'(busy), 64'd1);
        check_eq("post_rst_adr0", 64'(snoop_adr[31:0]), 64'h800);
        step();
        step();
        check_eq("post_rst_done", 64'(done), 64'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
